// File: rtl/f4_rd_ctrl_if.sv
// f4_rd_ctrl_if
// Bundles the F4 read-controller signals: the job handshake (start/busy/done),
// the F4 RAM read port (f4_raddr/f4_rd_en/f4_rdata) and the output stream
// (dout/dout_valid/dout_ready/dout_last/dout_pass).
//   master : the controller side (drives RAM address and stream outputs)
//   slave  : the environment side (drives start, RAM data and dout_ready)
interface f4_rd_ctrl_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7
);
  logic              start;
  logic [ADDR_W-1:0] f4_raddr;
  logic              f4_rd_en;
  logic [DATA_W-1:0] f4_rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic [3:0]        dout_pass;
  logic              busy;
  logic              done;

  modport master (
    input  start, f4_rdata, dout_ready,
    output f4_raddr, f4_rd_en, dout, dout_valid, dout_last, dout_pass, busy, done
  );

  modport slave (
    output start, f4_rdata, dout_ready,
    input  f4_raddr, f4_rd_en, dout, dout_valid, dout_last, dout_pass, busy, done
  );
endinterface

// File: rtl/f4_rd_ctrl.sv
// f4_rd_ctrl
// Read-side controller for the F4 feature buffer. A job sweeps RAM addresses
// 0..WORDS-1, PASSES times, and streams each word downstream on valid/ready.
// A 3-entry FIFO absorbs the 1-cycle RAM latency and downstream stalls; reads
// are only issued while (in-flight read + occupancy) < 3 so it never overflows.
// Ports:
//   clk  : single clock (RAM read port shares it)
//   rst  : asynchronous active-high reset
//   bus  : f4_rd_ctrl_if.master -- start/busy/done, RAM read port, output stream
module f4_rd_ctrl #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7,
  parameter int WORDS  = 100,
  parameter int PASSES = 10
) (
  input  logic          clk,
  input  logic          rst,
  f4_rd_ctrl_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [3:0]        LAST_PASS = 4'(PASSES - 1);
  localparam int                DEPTH     = 3;

  // Control state
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_word;
  logic [3:0]        r_pass;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_inflight;
  logic              r_tag_last;
  logic [3:0]        r_tag_pass;

  // Output FIFO
  logic [DATA_W-1:0] r_buf_data [DEPTH];
  logic              r_buf_last [DEPTH];
  logic [3:0]        r_buf_pass [DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_count;

  logic w_issue;
  logic w_word_last;
  logic w_pass_last;
  logic w_push;
  logic w_pop;
  logic w_done;
  logic [2:0] w_credit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the read still in the RAM pipeline; a pop this cycle is
  // deliberately not credited so the decision never depends on dout_ready.
  assign w_credit    = {2'b00, r_inflight} + {1'b0, r_count};
  assign w_issue     = (r_state == S_READ) && (w_credit < 3'd3);
  assign w_word_last = (r_word == LAST_ADDR);
  assign w_pass_last = (r_pass == LAST_PASS);

  // RAM data returns one cycle after the read, so the push follows r_inflight.
  assign w_push = r_inflight;
  assign w_pop  = (r_count != 2'd0) && bus.dout_ready;

  // The job ends when the very last word of the last pass leaves the FIFO.
  assign w_done = (r_state == S_FLUSH) && w_pop &&
                  r_buf_last[r_rd_ptr] && (r_buf_pass[r_rd_ptr] == LAST_PASS);

  // Address holds its last issued value when no read is issued.
  assign bus.f4_rd_en   = w_issue;
  assign bus.f4_raddr   = w_issue ? r_word : r_raddr;
  assign bus.dout       = r_buf_data[r_rd_ptr];
  assign bus.dout_last  = r_buf_last[r_rd_ptr];
  assign bus.dout_pass  = r_buf_pass[r_rd_ptr];
  assign bus.dout_valid = (r_count != 2'd0);
  assign bus.done       = w_done;
  assign bus.busy       = (r_state != S_IDLE) && !w_done;

  // Sweep control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_pass     <= '0;
      r_raddr    <= '0;
      r_inflight <= 1'b0;
      r_tag_last <= 1'b0;
      r_tag_pass <= '0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_word  <= '0;
            r_pass  <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_raddr    <= r_word;
            r_tag_last <= w_word_last;
            r_tag_pass <= r_pass;
            if (w_word_last) begin
              r_word <= '0;
              r_pass <= r_pass + 4'd1;
              if (w_pass_last) begin
                r_state <= S_FLUSH;
              end
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage; cleared on reset so dout/dout_last/dout_pass read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
        r_buf_pass[i] <= '0;
      end
    end else if (w_push) begin
      r_buf_data[r_wr_ptr] <= bus.f4_rdata;
      r_buf_last[r_wr_ptr] <= r_tag_last;
      r_buf_pass[r_wr_ptr] <= r_tag_pass;
    end
  end

endmodule

// File: tb/tb_f4_rd_ctrl.sv
// Testbench for f4_rd_ctrl: one single-pass and one three-pass instance,
// each with a RAM model returning word k = 32-bit k replicated.
module tb_f4_rd_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  f4_rd_ctrl_if #(.DATA_W(256), .ADDR_W(7)) if1 ();
  f4_rd_ctrl_if #(.DATA_W(256), .ADDR_W(7)) if3 ();

  f4_rd_ctrl #(.DATA_W(256), .ADDR_W(7), .WORDS(100), .PASSES(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  f4_rd_ctrl #(.DATA_W(256), .ADDR_W(7), .WORDS(100), .PASSES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] word_of(input int k);
    logic [31:0] w;
    w = k;
    return {8{w}};
  endfunction

  // RAM models: registered read, one cycle latency
  always @(posedge clk) begin
    if (if1.f4_rd_en) if1.f4_rdata <= word_of(int'(if1.f4_raddr));
    if (if3.f4_rd_en) if3.f4_rdata <= word_of(int'(if3.f4_raddr));
  end

  task automatic test_reset();
    rst = 1'b1;
    if1.start = 1'b0; if1.dout_ready = 1'b0;
    if3.start = 1'b0; if3.dout_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (if1.dout_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if1.dout_valid); end
    checks++; if (if1.f4_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", if1.f4_rd_en); end
    checks++; if (if1.f4_raddr !== 7'd0) begin failures++; $display("FAIL rst_raddr got=%0d exp=0", if1.f4_raddr); end
    checks++; if (if1.dout !== 256'd0) begin failures++; $display("FAIL rst_dout got=%h exp=0", if1.dout); end
    checks++; if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", if1.busy, if1.done); end
    checks++; if (if3.dout_valid !== 1'b0 || if3.dout_pass !== 4'd0 || if3.dout_last !== 1'b0) begin
      failures++; $display("FAIL rst_dut3 got valid=%b pass=%0d last=%b exp=0", if3.dout_valid, if3.dout_pass, if3.dout_last);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic exp_done;
    int   k;
    @(negedge clk); if1.dout_ready = 1'b1; if1.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 105; c++) begin
      @(negedge clk); if1.start = 1'b0; #1;
      if (c == 1) begin
        checks++; if (if1.f4_rd_en !== 1'b1 || if1.f4_raddr !== 7'd0) begin
          failures++; $display("FAIL basic_first_read got en=%b addr=%0d exp en=1 addr=0", if1.f4_rd_en, if1.f4_raddr);
        end
        checks++; if (if1.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", if1.busy); end
      end
      if (c == 2) begin
        checks++; if (if1.dout_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_c2 got=%b exp=0", if1.dout_valid); end
      end
      if (c >= 3 && c <= 102) begin
        k = c - 3;
        checks++; if (if1.dout_valid !== 1'b1 || if1.dout !== word_of(k)) begin
          failures++; $display("FAIL basic_data c=%0d got valid=%b dout=%h exp=%h", c, if1.dout_valid, if1.dout, word_of(k));
        end
        checks++; if (if1.dout_last !== (k == 99)) begin
          failures++; $display("FAIL basic_last c=%0d got=%b exp=%b", c, if1.dout_last, (k == 99));
        end
      end
      if (c == 101) begin
        checks++; if (if1.f4_rd_en !== 1'b0 || if1.f4_raddr !== 7'd99) begin
          failures++; $display("FAIL basic_addr_hold got en=%b addr=%0d exp en=0 addr=99", if1.f4_rd_en, if1.f4_raddr);
        end
      end
      exp_done = (c == 102);
      checks++; if (if1.done !== exp_done) begin
        failures++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, if1.done, exp_done);
      end
      if (c == 103) begin
        checks++; if (if1.dout_valid !== 1'b0 || if1.busy !== 1'b0) begin
          failures++; $display("FAIL basic_idle got valid=%b busy=%b exp 0 0", if1.dout_valid, if1.busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); if1.dout_ready = 1'b1; if1.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 104; c++) begin
      @(negedge clk); if1.start = (c == 102 || c == 103); #1;
      if (c == 102) begin
        checks++; if (if1.done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", if1.done); end
      end
      if (c == 103) begin
        checks++; if (if1.busy !== 1'b0 || if1.f4_rd_en !== 1'b0) begin
          failures++; $display("FAIL b2b_start_ignored got busy=%b en=%b exp 0 0", if1.busy, if1.f4_rd_en);
        end
      end
      if (c == 104) begin
        checks++; if (if1.busy !== 1'b1 || if1.f4_rd_en !== 1'b1 || if1.f4_raddr !== 7'd0) begin
          failures++; $display("FAIL b2b_restart got busy=%b en=%b addr=%0d exp 1 1 0", if1.busy, if1.f4_rd_en, if1.f4_raddr);
        end
      end
    end
    if1.start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_midjob();
    @(negedge clk); if1.dout_ready = 1'b1; if1.start = 1'b1;    // cycle 0
    for (int c = 1; c < 40; c++) begin
      @(negedge clk); if1.start = 1'b0;
    end
    @(negedge clk); rst = 1'b1; #1;                             // cycle 40
    checks++; if (if1.dout_valid !== 1'b0 || if1.dout !== 256'd0 || if1.dout_last !== 1'b0 || if1.dout_pass !== 4'd0) begin
      failures++; $display("FAIL midrst_stream got valid=%b last=%b pass=%0d dout=%h exp all 0", if1.dout_valid, if1.dout_last, if1.dout_pass, if1.dout);
    end
    checks++; if (if1.f4_rd_en !== 1'b0 || if1.f4_raddr !== 7'd0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl got en=%b addr=%0d busy=%b done=%b exp all 0", if1.f4_rd_en, if1.f4_raddr, if1.busy, if1.done);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (if1.dout_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_stale got valid=%b exp=0", if1.dout_valid); end
    @(negedge clk); if1.start = 1'b1;                           // cycle 0
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); if1.start = 1'b0; #1;
      if (c == 1) begin
        checks++; if (if1.f4_rd_en !== 1'b1 || if1.f4_raddr !== 7'd0) begin
          failures++; $display("FAIL midrst_restart got en=%b addr=%0d exp 1 0", if1.f4_rd_en, if1.f4_raddr);
        end
      end
      if (c == 3) begin
        checks++; if (if1.dout_valid !== 1'b1 || if1.dout !== word_of(0) || if1.dout_pass !== 4'd0) begin
          failures++; $display("FAIL midrst_first_word got valid=%b pass=%0d dout=%h exp word 0 pass 0", if1.dout_valid, if1.dout_pass, if1.dout);
        end
      end
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_stall();
    int idx = 0;
    int issued = 0;
    int popped = 0;
    bit finished = 0;
    @(negedge clk); if1.dout_ready = 1'b1; if1.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 400 && !finished; c++) begin
      @(negedge clk); if1.start = 1'b0; if1.dout_ready = !(c >= 5 && c <= 20); #1;
      if (if1.f4_rd_en) issued++;
      if (c >= 6 && c <= 20) begin
        checks++; if (if1.f4_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en c=%0d got=%b exp=0", c, if1.f4_rd_en); end
        checks++; if (if1.dout_valid !== 1'b1 || if1.dout !== word_of(2)) begin
          failures++; $display("FAIL stall_head c=%0d got valid=%b dout=%h exp word 2", c, if1.dout_valid, if1.dout);
        end
      end
      if (c >= 7 && c <= 20) begin
        checks++; if (issued - popped != 3) begin failures++; $display("FAIL stall_buffered c=%0d got=%0d exp=3", c, issued - popped); end
      end
      if (c == 21) begin
        checks++; if (if1.f4_rd_en !== 1'b0) begin failures++; $display("FAIL stall_release_c21 got en=%b exp=0", if1.f4_rd_en); end
      end
      if (c == 22) begin
        checks++; if (if1.f4_rd_en !== 1'b1 || if1.f4_raddr !== 7'd5) begin
          failures++; $display("FAIL stall_resume got en=%b addr=%0d exp 1 5", if1.f4_rd_en, if1.f4_raddr);
        end
      end
      if (if1.dout_valid && if1.dout_ready) begin
        checks++; if (if1.dout !== word_of(idx) || if1.dout_last !== (idx == 99)) begin
          failures++; $display("FAIL stall_order idx=%0d got dout=%h last=%b exp=%h", idx, if1.dout, if1.dout_last, word_of(idx));
        end
        idx++; popped++;
        if (if1.done) begin
          finished = 1;
          checks++; if (idx != 100) begin failures++; $display("FAIL stall_done_count got=%0d exp=100", idx); end
        end
      end
    end
    checks++; if (!finished) begin failures++; $display("FAIL stall_timeout got words=%0d exp done", idx); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    @(negedge clk); if1.dout_ready = 1'b1; if1.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk); if1.start = (c == 10 || c == 50); #1;
      if (if1.done) ndone++;
      if (c == 11 || c == 51) begin
        checks++; if (if1.f4_raddr !== 7'(c - 1)) begin
          failures++; $display("FAIL ign_addr c=%0d got=%0d exp=%0d", c, if1.f4_raddr, c - 1);
        end
      end
      if (c >= 3 && c <= 102 && (c % 10 == 0)) begin
        checks++; if (if1.dout !== word_of(c - 3)) begin
          failures++; $display("FAIL ign_data c=%0d got=%h exp=%h", c, if1.dout, word_of(c - 3));
        end
      end
      if (c == 102) begin
        checks++; if (if1.done !== 1'b1) begin failures++; $display("FAIL ign_done_c102 got=%b exp=1", if1.done); end
      end
    end
    if1.start = 1'b0;
    checks++; if (ndone != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_multipass();
    int nlast = 0;
    int idx;
    logic exp_done;
    @(negedge clk); if3.dout_ready = 1'b1; if3.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 306; c++) begin
      @(negedge clk); if3.start = 1'b0; #1;
      if (if3.dout_valid && if3.dout_last) nlast++;
      if (c >= 3 && c <= 302) begin
        idx = c - 3;
        checks++; if (if3.dout_valid !== 1'b1 || if3.dout !== word_of(idx % 100)) begin
          failures++; $display("FAIL mp_data c=%0d got valid=%b dout=%h exp=%h", c, if3.dout_valid, if3.dout, word_of(idx % 100));
        end
        checks++; if (if3.dout_pass !== 4'(idx / 100) || if3.dout_last !== ((idx % 100) == 99)) begin
          failures++; $display("FAIL mp_tag c=%0d got pass=%0d last=%b exp pass=%0d last=%b", c, if3.dout_pass, if3.dout_last, idx / 100, (idx % 100) == 99);
        end
      end
      exp_done = (c == 302);
      checks++; if (if3.done !== exp_done) begin failures++; $display("FAIL mp_done c=%0d got=%b exp=%b", c, if3.done, exp_done); end
    end
    checks++; if (nlast != 3) begin failures++; $display("FAIL mp_last_count got=%0d exp=3", nlast); end
  endtask

  task automatic test_random_bp();
    int idx = 0;
    int issued = 0;
    int popped = 0;
    bit finished = 0;
    bit prev_hold = 0;
    logic [255:0] prev_dout = '0;
    @(negedge clk); if3.dout_ready = 1'b0; if3.start = 1'b1;    // cycle 0
    for (int c = 1; c <= 4000 && !finished; c++) begin
      @(negedge clk); if3.start = 1'b0; if3.dout_ready = ($urandom_range(0, 9) < 3); #1;
      if (if3.f4_rd_en) issued++;
      checks++; if (issued - popped > 3) begin failures++; $display("FAIL rnd_overflow c=%0d got=%0d exp<=3", c, issued - popped); end
      if (prev_hold) begin
        checks++; if (if3.dout_valid !== 1'b1 || if3.dout !== prev_dout) begin
          failures++; $display("FAIL rnd_stable c=%0d got valid=%b dout=%h exp=%h", c, if3.dout_valid, if3.dout, prev_dout);
        end
      end
      if (if3.dout_valid && if3.dout_ready) begin
        checks++; if (if3.dout !== word_of(idx % 100) || if3.dout_pass !== 4'(idx / 100)) begin
          failures++; $display("FAIL rnd_order idx=%0d got dout=%h pass=%0d exp=%h pass=%0d", idx, if3.dout, if3.dout_pass, word_of(idx % 100), idx / 100);
        end
        idx++; popped++;
      end
      if (if3.done) begin
        finished = 1;
        checks++; if (idx != 300) begin failures++; $display("FAIL rnd_done_count got=%0d exp=300", idx); end
      end
      prev_hold = if3.dout_valid && !if3.dout_ready;
      prev_dout = if3.dout;
    end
    checks++; if (!finished) begin failures++; $display("FAIL rnd_timeout got words=%0d exp done", idx); end
    if3.dout_ready = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midjob();
    test_stall();
    test_start_ignored();
    test_multipass();
    test_random_bp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
